// File: rtl/wvb_pkg.sv
// wvb_pkg: shared header field offsets, output word layout and reader FSM states
package wvb_pkg;
  localparam int STOP_LSB = 0;
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_SAMP, S_DRAIN, S_DONE} state_t;
  function automatic int start_lsb(input int adr_width);
    return STOP_LSB + adr_width;
  endfunction
  function automatic int last_bit(input int out_width);
    return out_width - 1;
  endfunction
endpackage

// File: rtl/wvb_reader_if.sv
// wvb_reader_if: header FIFO, waveform RAM and output stream signals of one readout channel
interface wvb_reader_if #(
  parameter int P_DATA_WIDTH = 22,
  parameter int P_HDR_WIDTH = 160,
  parameter int P_OUT_WIDTH = 32
);
  logic hdr_empty;
  logic [P_HDR_WIDTH-1:0] hdr_data;
  logic hdr_rdreq;
  logic [P_DATA_WIDTH-1:0] wvb_data;
  logic wvb_rdreq;
  logic wvb_rddone;
  logic [P_OUT_WIDTH-1:0] dout;
  logic dout_valid;
  logic dout_ready;
  modport master(
    input hdr_empty, hdr_data, wvb_data, dout_ready,
    output hdr_rdreq, wvb_rdreq, wvb_rddone, dout, dout_valid
  );
  modport slave(
    output hdr_empty, hdr_data, wvb_data, dout_ready,
    input hdr_rdreq, wvb_rdreq, wvb_rddone, dout, dout_valid
  );
endinterface

// File: rtl/wvb_rd_skid.sv
// wvb_rd_skid: 2-entry output FIFO with valid/ready side and an occupancy level for read credits
module wvb_rd_skid #(
  parameter int P_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  input logic push,
  input logic [P_WIDTH-1:0] din,
  output logic [P_WIDTH-1:0] dout,
  output logic valid,
  input logic ready,
  output logic [1:0] level
);
  logic [P_WIDTH-1:0] mem [2];
  logic wp, rp;
  logic pop;
  assign valid = level != 2'd0;
  assign pop = valid & ready;
  assign dout = mem[rp];
  // storage and pointers; entries are cleared on reset so dout reads zero
  always_ff @(posedge clk)
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      level <= 2'd0;
    end else begin
      if (push) mem[wp] <= din;
      wp <= wp ^ push;
      rp <= rp ^ pop;
      level <= level + {1'b0, push} - {1'b0, pop};
    end
endmodule

// File: rtl/wvb_reader.sv
// wvb_reader: pops one waveform header, streams it out, then streams every stored sample
module wvb_reader
  import wvb_pkg::*;
#(
  parameter int P_DATA_WIDTH = 22,
  parameter int P_ADR_WIDTH = 12,
  parameter int P_HDR_WIDTH = 160,
  parameter int P_LTC_WIDTH = 48,
  parameter int P_OUT_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  input logic en,
  wvb_reader_if.master bus,
  output logic busy,
  output logic [15:0] n_read
);
  localparam int H = P_HDR_WIDTH / P_OUT_WIDTH;
  localparam int BW = H > 1 ? $clog2(H) : 1;
  localparam int NW = P_ADR_WIDTH + 1;
  localparam int START_LSB = start_lsb(P_ADR_WIDTH);
  localparam int LAST_BIT = last_bit(P_OUT_WIDTH);
  if (P_HDR_WIDTH % P_OUT_WIDTH != 0 || P_OUT_WIDTH < P_DATA_WIDTH + 1 ||
      P_HDR_WIDTH < 2 * P_ADR_WIDTH + P_LTC_WIDTH) begin : g_bad_params
    $error("wvb_reader: inconsistent width parameters");
  end
  state_t state;
  logic [P_HDR_WIDTH-1:0] hdr_q;
  logic [BW-1:0] beat;
  logic [NW-1:0] n, issued, pushed;
  logic rd_pend;
  logic [1:0] level;
  logic pop, hdr_push, samp_push, push, last_beat, last_issue, last_push;
  logic [2:0] occ;
  logic [P_OUT_WIDTH-1:0] samp_word, din;
  // occ is the skid occupancy after this cycle; a read lands next cycle so it needs occ < 2
  always_comb begin
    pop = bus.dout_valid & bus.dout_ready;
    hdr_push = state == S_HDR && (level != 2'd2 || pop);
    samp_push = rd_pend;
    push = hdr_push | samp_push;
    last_beat = beat == BW'(H - 1);
    last_issue = issued + NW'(1) == n;
    last_push = pushed + NW'(1) == n;
    occ = {1'b0, level} - {2'b0, pop} + {2'b0, push};
    bus.hdr_rdreq = state == S_IDLE && en && !bus.hdr_empty;
    bus.wvb_rdreq = (state == S_SAMP || (hdr_push && last_beat)) && occ < 3'd2;
    samp_word = P_OUT_WIDTH'(bus.wvb_data);
    samp_word[LAST_BIT] = last_push;
    din = hdr_push ? hdr_q[P_HDR_WIDTH-1 -: P_OUT_WIDTH] : samp_word;
  end
  assign bus.wvb_rddone = state == S_DONE;
  assign busy = state != S_IDLE;
  wvb_rd_skid #(.P_WIDTH(P_OUT_WIDTH)) u_skid (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din(din),
    .dout(bus.dout),
    .valid(bus.dout_valid),
    .ready(bus.dout_ready),
    .level(level)
  );
  // readout FSM; the first read overlaps the last header beat to reach sample data at cycle 2+H
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      hdr_q <= '0;
      beat <= '0;
      n <= '0;
      issued <= '0;
      pushed <= '0;
      rd_pend <= 1'b0;
      n_read <= '0;
    end else begin
      rd_pend <= bus.wvb_rdreq;
      if (bus.wvb_rdreq) issued <= issued + NW'(1);
      if (samp_push) pushed <= pushed + NW'(1);
      case (state)
        S_IDLE:
          if (bus.hdr_rdreq) begin
            hdr_q <= bus.hdr_data;
            n <= {1'b0, bus.hdr_data[STOP_LSB +: P_ADR_WIDTH] - bus.hdr_data[START_LSB +: P_ADR_WIDTH]} + NW'(1);
            beat <= '0;
            issued <= '0;
            pushed <= '0;
            state <= S_HDR;
          end
        S_HDR:
          if (hdr_push) begin
            hdr_q <= hdr_q << P_OUT_WIDTH;
            beat <= beat + BW'(1);
            if (last_beat) state <= bus.wvb_rdreq && last_issue ? S_DRAIN : S_SAMP;
          end
        S_SAMP: if (bus.wvb_rdreq && last_issue) state <= S_DRAIN;
        S_DRAIN: if (samp_push && last_push) state <= S_DONE;
        default: begin
          n_read <= n_read + 16'd1;
          state <= S_IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_wvb_reader.sv
// tb_wvb_reader: vector table, hand sequences and random waveforms against a header-FIFO/RAM model
module tb_wvb_reader;
  localparam int H = 5;
  typedef struct {
    logic [11:0] start;
    logic [11:0] stop;
    int pct;
    int n;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic busy;
  logic [15:0] n_read;
  int n_chk = 0, n_fail = 0;
  logic [21:0] ram [4096];
  logic [11:0] addr = '0;
  logic [159:0] hq[$];
  logic [31:0] exp_q[$];
  int pops = 0, rds = 0, dones = 0, beats = 0, cyc = 0, rdy_pct = 100;
  int t_hdr = 0, t_first = 0, t_samp0 = 0, t_done = 0, wbeats = 0;
  bit hp, rp, stall;
  logic [31:0] stall_d;
  logic [159:0] eh;
  logic [31:0] ew;
  int es, en_n;
  vec_t vecs[5];

  wvb_reader_if #(.P_DATA_WIDTH(22), .P_HDR_WIDTH(160), .P_OUT_WIDTH(32)) bus();
  wvb_reader #(
    .P_DATA_WIDTH(22), .P_ADR_WIDTH(12), .P_HDR_WIDTH(160), .P_LTC_WIDTH(48), .P_OUT_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .bus(bus), .busy(busy), .n_read(n_read)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #3;
  endtask

  // header FIFO, RAM and stream monitor; observes at negedge, applies effects just after posedge
  always begin
    @(negedge clk);
    hp = 1'b0;
    rp = 1'b0;
    if (rst) stall = 1'b0;
    else begin
      if (bus.hdr_rdreq | bus.wvb_rdreq) chk("rdreq_exclusive", bus.hdr_rdreq & bus.wvb_rdreq, 0);
      if (stall) begin
        chk("hold_valid", bus.dout_valid, 1);
        chk("hold_data", bus.dout, stall_d);
      end
      if (bus.hdr_rdreq) begin
        hp = 1'b1;
        pops++;
        t_hdr = cyc;
        wbeats = 0;
        if (hq.size() == 0) chk("hdr_pop_when_empty", 1, 0);
        else begin
          eh = hq[0];
          es = int'(eh[23:12]);
          en_n = ((int'(eh[11:0]) - es) & 4095) + 1;
          for (int k = 0; k < H; k++) exp_q.push_back(eh[(H-k)*32-1 -: 32]);
          for (int i = 0; i < en_n; i++) begin
            ew = 32'(ram[(es + i) & 4095]);
            ew[31] = i == en_n - 1;
            exp_q.push_back(ew);
          end
        end
      end
      if (bus.wvb_rdreq) begin
        rp = 1'b1;
        rds++;
      end
      if (bus.dout_valid & bus.dout_ready) begin
        if (wbeats == 0) t_first = cyc;
        if (wbeats == H) t_samp0 = cyc;
        wbeats++;
        beats++;
        if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
        else chk("dout", bus.dout, exp_q.pop_front());
      end
      if (bus.wvb_rddone) begin
        dones++;
        t_done = cyc;
      end
      stall = bus.dout_valid & !bus.dout_ready;
      stall_d = bus.dout;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (hp && hq.size() > 0) begin
      addr = hq[0][23:12];
      void'(hq.pop_front());
    end
    if (rp) begin
      bus.wvb_data = ram[addr];
      addr = addr + 12'd1;
    end
    bus.hdr_empty = hq.size() == 0;
    bus.hdr_data = hq.size() > 0 ? hq[0] : '0;
    bus.dout_ready = int'($urandom_range(99)) < rdy_pct;
  end

  task automatic push_hdr(input logic [11:0] st, input logic [11:0] sp);
    logic [159:0] h;
    for (int i = 0; i < 5; i++) h[i*32 +: 32] = $urandom;
    h[11:0] = sp;
    h[23:12] = st;
    hq.push_back(h);
  endtask

  task automatic wait_dones(input int tgt, input string nm);
    int k = 0;
    while (dones < tgt && k < 20000) begin
      tick;
      k++;
    end
    chk({nm, "_done_timeout"}, dones >= tgt, 1);
  endtask

  task automatic wait_drain(input string nm);
    int k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      tick;
      k++;
    end
    chk({nm, "_drain_timeout"}, exp_q.size(), 0);
  endtask

  task automatic run_wave(input string nm, input logic [11:0] st, input logic [11:0] sp, input int pct, input int n);
    int p0, r0, b0, d0, k;
    logic [15:0] nr0;
    p0 = pops; r0 = rds; b0 = beats; d0 = dones; nr0 = n_read; k = 0;
    rdy_pct = pct;
    push_hdr(st, sp);
    while (pops == p0 && k < 100) begin
      tick;
      k++;
    end
    chk({nm, "_busy_high"}, busy, 1);
    wait_dones(d0 + 1, nm);
    wait_drain(nm);
    chk({nm, "_hdr_pops"}, pops - p0, 1);
    chk({nm, "_rd_count"}, rds - r0, n);
    chk({nm, "_beats"}, beats - b0, H + n);
    chk({nm, "_rddone"}, dones - d0, 1);
    chk({nm, "_n_read"}, n_read, nr0 + 16'd1);
    chk({nm, "_busy_low"}, busy, 0);
    if (pct == 100) begin
      chk({nm, "_lat_hdr"}, t_first - t_hdr, 2);
      chk({nm, "_lat_samp"}, t_samp0 - t_hdr, 2 + H);
      chk({nm, "_lat_done"}, t_done - t_hdr, 6 + n);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, r0, d0, k, len, pct;
    logic [11:0] st;
    logic [15:0] nr0;
    for (int i = 0; i < 4096; i++) ram[i] = 22'($urandom);
    vecs[0] = '{12'h010, 12'h013, 100, 4};
    vecs[1] = '{12'hFFE, 12'h001, 100, 4};
    vecs[2] = '{12'h100, 12'h100, 100, 1};
    vecs[3] = '{12'h200, 12'h23F, 30, 64};
    vecs[4] = '{12'h7F0, 12'h7EF, 100, 4096};
    repeat (3) tick;
    chk("rst_hdr_rdreq", bus.hdr_rdreq, 0);
    chk("rst_wvb_rdreq", bus.wvb_rdreq, 0);
    chk("rst_rddone", bus.wvb_rddone, 0);
    chk("rst_valid", bus.dout_valid, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_n_read", n_read, 0);
    rst = 1'b0;
    tick;
    en = 1'b1;
    for (int i = 0; i < 5; i++)
      run_wave($sformatf("vec%0d", i), vecs[i].start, vecs[i].stop, vecs[i].pct, vecs[i].n);
    for (int i = 0; i < 6; i++) begin
      st = 12'($urandom_range(4095));
      len = int'($urandom_range(48, 1));
      pct = i % 3 == 0 ? 100 : int'($urandom_range(80, 20));
      run_wave($sformatf("rand%0d", i), st, st + 12'(len - 1), pct, len);
    end
    p0 = pops; r0 = rds; d0 = dones; nr0 = n_read; k = 0;
    rdy_pct = 100;
    push_hdr(12'h300, 12'h309);
    push_hdr(12'h400, 12'h404);
    while (pops == p0 && k < 100) begin
      tick;
      k++;
    end
    repeat (3) tick;
    en = 1'b0;
    wait_dones(d0 + 1, "queued_first");
    repeat (20) tick;
    chk("queued_held_pops", pops - p0, 1);
    chk("queued_held_busy", busy, 0);
    chk("queued_held_n_read", n_read, nr0 + 16'd1);
    en = 1'b1;
    wait_dones(d0 + 2, "queued_second");
    wait_drain("queued");
    chk("queued_pops", pops - p0, 2);
    chk("queued_rds", rds - r0, 15);
    chk("queued_n_read", n_read, nr0 + 16'd2);
    p0 = pops; r0 = rds; d0 = dones; k = 0;
    push_hdr(12'h000, 12'h013);
    while (rds - r0 < 10 && k < 200) begin
      tick;
      k++;
    end
    chk("midrst_reads_reached", rds - r0 >= 10, 1);
    rst = 1'b1;
    tick;
    chk("midrst_hdr_rdreq", bus.hdr_rdreq, 0);
    chk("midrst_wvb_rdreq", bus.wvb_rdreq, 0);
    chk("midrst_rddone", bus.wvb_rddone, 0);
    chk("midrst_valid", bus.dout_valid, 0);
    chk("midrst_dout", bus.dout, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_n_read", n_read, 0);
    hq.delete();
    exp_q.delete();
    tick;
    rst = 1'b0;
    repeat (8) tick;
    chk("midrst_no_rddone", dones - d0, 0);
    chk("midrst_idle", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
